// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match sequencer and its neighbours:
// point/tick/start inputs in, scores and game status out.
interface pong_match_ctrl_if;
  logic       tick_en;
  logic       start;
  logic       point_p1;
  logic       point_p2;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       ball_enable;
  logic       serve_dir;
  logic       game_over;
  logic       winner;
  logic [1:0] state;

  // master drives the events and observes status
  modport master (
    output tick_en, start, point_p1, point_p2,
    input  score_p1, score_p2, ball_enable, serve_dir, game_over, winner, state
  );

  // slave is the match sequencer itself
  modport slave (
    input  tick_en, start, point_p1, point_p2,
    output score_p1, score_p2, ball_enable, serve_dir, game_over, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: keeps both scores, gates the ball, times the
// post-point pause, picks the serve direction and flags the winner.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE  = 9,
  parameter int unsigned HOLD_TICKS = 1000,
  parameter int unsigned CW         = 10
) (
  input logic               clk,
  input logic               reset,
  pong_match_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StHold = 2'b10,
    StOver = 2'b11
  } state_e;

  localparam logic [3:0]    WinScore = 4'(WIN_SCORE);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_TICKS - 1);

  state_e        state_q, state_d;
  logic [3:0]    score_p1_q, score_p1_d;
  logic [3:0]    score_p2_q, score_p2_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          serve_dir_q, serve_dir_d;
  logic          winner_q, winner_d;
  logic          ball_enable_q, ball_enable_d;
  logic          game_over_q, game_over_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      score_p1_q    <= 4'd0;
      score_p2_q    <= 4'd0;
      hold_q        <= '0;
      serve_dir_q   <= 1'b0;
      winner_q      <= 1'b0;
      ball_enable_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      hold_q        <= hold_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      ball_enable_q <= ball_enable_d;
      game_over_q   <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    hold_d      = hold_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StPlay;
      end
      StPlay: begin
        hold_d = '0;
        if (bus.point_p1 && bus.point_p2) begin
          // simultaneous hits: replay the point without scoring
          state_d = StHold;
        end else if (bus.point_p1) begin
          score_p1_d = score_p1_q + 4'd1;
          if (score_p1_d == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b0;
          end else begin
            state_d     = StHold;
            serve_dir_d = 1'b1;
          end
        end else if (bus.point_p2) begin
          score_p2_d = score_p2_q + 4'd1;
          if (score_p2_d == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b1;
          end else begin
            state_d     = StHold;
            serve_dir_d = 1'b0;
          end
        end
      end
      StHold: begin
        if (bus.tick_en) begin
          if (hold_q == HoldLast) begin
            state_d = StPlay;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
      end
      StOver: begin
        if (bus.start) begin
          state_d     = StPlay;
          score_p1_d  = 4'd0;
          score_p2_d  = 4'd0;
          serve_dir_d = ~winner_q;
        end
      end
    endcase

    // status flags are registered alongside the state they decode
    ball_enable_d = (state_d == StPlay);
    game_over_d   = (state_d == StOver);
  end

  assign bus.score_p1    = score_p1_q;
  assign bus.score_p2    = score_p2_q;
  assign bus.ball_enable = ball_enable_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE = 3 and HOLD_TICKS = 4:
// a vector table for a full match plus hand sequences for reset and auto-restart.
module tb_pong_match_ctrl;
  localparam int unsigned WinScore  = 3;
  localparam int unsigned HoldTicks = 4;
  localparam int unsigned Cw        = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE (WinScore),
    .HOLD_TICKS(HoldTicks),
    .CW        (Cw)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit         tick;
    bit         start;
    bit         p1;
    bit         p2;
    logic [1:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    bit         be;
    bit         sd;
    bit         go;
    bit         win;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit tick, bit start, bit p1, bit p2, logic [1:0] st,
                              logic [3:0] s1, logic [3:0] s2, bit be, bit sd, bit go, bit win);
    vec_t v;
    v.tick = tick; v.start = start; v.p1 = p1; v.p2 = p2;
    v.st = st; v.s1 = s1; v.s2 = s2; v.be = be; v.sd = sd; v.go = go; v.win = win;
    return v;
  endfunction

  // drive inputs away from the active edge, sample 1 time unit after it
  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.tick_en  = v.tick;
    bus.start    = v.start;
    bus.point_p1 = v.p1;
    bus.point_p2 = v.p2;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [14:0] act, exp;
    act = {bus.state, bus.score_p1, bus.score_p2, bus.ball_enable, bus.serve_dir,
           bus.game_over, bus.winner};
    exp = {v.st, v.s1, v.s2, v.be, v.sd, v.go, v.win};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st=%b s1=%0d s2=%0d be=%b sd=%b go=%b win=%b, want st=%b s1=%0d s2=%0d be=%b sd=%b go=%b win=%b",
               name, act[14:13], act[12:9], act[8:5], act[4], act[3], act[2], act[1],
               v.st, v.s1, v.s2, v.be, v.sd, v.go, v.win);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    apply(v);
    check(name, v);
  endtask

  // four idle ticks in HOLD; the last one returns to PLAY
  task automatic pause(input string name, input bit start, input logic [3:0] s1,
                       input logic [3:0] s2, input bit sd, input bit win);
    for (int i = 0; i < 3; i++) step(name, mk(1, start, 0, 0, 2'b10, s1, s2, 0, sd, 0, win));
    step(name, mk(1, start, 0, 0, 2'b01, s1, s2, 1, sd, 0, win));
  endtask

  initial begin
    bus.tick_en = 1'b0; bus.start = 1'b0; bus.point_p1 = 1'b0; bus.point_p2 = 1'b0;

    //             tk st p1 p2  state  s1 s2 be sd go win
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // point in IDLE ignored
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // tick in IDLE ignored
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0)); // start -> PLAY
    vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, 0)); // P1 scores
    vecs.push_back(mk(0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, 0)); // point in HOLD ignored
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0)); // tick 1
    vecs.push_back(mk(0, 1, 0, 1, 2'b10, 1, 0, 0, 1, 0, 0)); // start/point in HOLD ignored
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0)); // tick 2
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0)); // tick 3
    vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 0, 1, 1, 0, 0)); // tick 4 -> PLAY
    vecs.push_back(mk(0, 0, 1, 1, 2'b10, 1, 0, 0, 1, 0, 0)); // both hit: replay
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'b10, 1, 1, 0, 0, 0, 0)); // P2 scores
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'b10, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b10, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'b11, 1, 3, 0, 0, 1, 1)); // P2 reaches 3 -> OVER
    vecs.push_back(mk(0, 0, 1, 0, 2'b11, 1, 3, 0, 0, 1, 1)); // frozen in OVER
    vecs.push_back(mk(0, 0, 0, 1, 2'b11, 1, 3, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 2'b11, 1, 3, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 0, 0, 1, 0, 0, 1)); // restart, serve toward P1

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // climb to 2/1 and reset in the middle of the pause
    step("seqA_p1a", mk(0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, 1));
    pause("seqA_hold1", 0, 1, 0, 1, 1);
    step("seqA_p1b", mk(0, 0, 1, 0, 2'b10, 2, 0, 0, 1, 0, 1));
    pause("seqA_hold2", 0, 2, 0, 1, 1);
    step("seqA_p2", mk(0, 0, 0, 1, 2'b10, 2, 1, 0, 0, 0, 1));
    step("seqA_tick", mk(1, 0, 0, 0, 2'b10, 2, 1, 0, 0, 0, 1));
    @(negedge clk);
    reset = 1'b1;
    bus.tick_en = 1'b1;
    @(posedge clk);
    #1;
    check("seqA_reset", mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("seqA_post_tick", mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    // start held high: P1 wins, then the match restarts on the very next edge
    step("seqB_start", mk(0, 1, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0));
    step("seqB_p1a", mk(0, 1, 1, 0, 2'b10, 1, 0, 0, 1, 0, 0));
    pause("seqB_hold1", 1, 1, 0, 1, 0);
    step("seqB_p1b", mk(0, 1, 1, 0, 2'b10, 2, 0, 0, 1, 0, 0));
    pause("seqB_hold2", 1, 2, 0, 1, 0);
    @(negedge clk);
    bus.tick_en = 1'b0; bus.start = 1'b0; bus.point_p1 = 1'b1; bus.point_p2 = 1'b0;
    @(posedge clk);
    #1;
    check("seqB_win", mk(0, 0, 0, 0, 2'b11, 3, 0, 0, 1, 1, 0));
    step("seqB_restart", mk(0, 1, 0, 0, 2'b01, 0, 0, 1, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
